// File: rtl/imem_fill_if.sv
// Cache-side line request bus plus backing-memory read port of the I-cache line-fill responder.
// The slave modport is the responder's view; master is the cache/memory environment.
interface imem_fill_if #(
  parameter int LINE    = 256,
  parameter int MEM_W   = 64,
  parameter int BLK_LEN = 59
);
  logic [BLK_LEN-1:0] b_addr_i;
  logic               b_rd_i;
  logic [LINE-1:0]    b_data_i;
  logic               b_dv_i;
  logic               inv;
  logic [63:0]        m_addr;
  logic               m_rd;
  logic [MEM_W-1:0]   m_data;
  logic               m_ack;

  modport slave (
    input  b_addr_i, b_rd_i, inv, m_data, m_ack,
    output b_data_i, b_dv_i, m_addr, m_rd
  );

  modport master (
    output b_addr_i, b_rd_i, inv, m_data, m_ack,
    input  b_data_i, b_dv_i, m_addr, m_rd
  );
endinterface

// File: rtl/imem_fill.sv
// I-cache line-fill responder: fetches a line as MEM_W-bit beats, assembles it, and
// keeps the last filled line in a one-entry buffer for back-to-back repeat requests.
module imem_fill #(
  parameter int LINE    = 256,
  parameter int MEM_W   = 64,
  parameter int BLK_LEN = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_fill_if.slave  bus
);
  localparam int BEATS = LINE / MEM_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LOFF  = $clog2(LINE / 8);
  localparam int BOFF  = $clog2(MEM_W / 8);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [BW-1:0]      r_beat, w_beat_nxt;
  logic               r_buf_v, w_buf_v_nxt;
  logic [BLK_LEN-1:0] r_buf_addr, w_buf_addr_nxt;
  logic [LINE-1:0]    r_data;
  logic               w_hit;
  logic               w_beat_we;
  logic [63:0]        w_line_base;

  assign w_line_base  = 64'({r_buf_addr, {LOFF{1'b0}}});
  assign w_beat_we    = (r_state == REQ) && bus.m_ack;

  // Handshake outputs come from registered state only, never from b_rd_i.
  assign bus.m_rd     = (r_state == REQ) || (r_state == DRAIN);
  assign bus.b_dv_i   = (r_state == DONE);
  assign bus.m_addr   = w_line_base + (64'(r_beat) << BOFF);
  assign bus.b_data_i = r_data;

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_nxt     = r_beat;
    w_buf_v_nxt    = r_buf_v && !bus.inv;
    w_buf_addr_nxt = r_buf_addr;
    w_hit          = bus.b_rd_i && r_buf_v && !bus.inv && (bus.b_addr_i == r_buf_addr);

    unique case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = DONE;
        end else if (bus.b_rd_i) begin
          w_buf_addr_nxt = bus.b_addr_i;
          w_buf_v_nxt    = 1'b0;
          w_beat_nxt     = '0;
          w_state_nxt    = REQ;
        end
      end
      REQ: begin
        if (bus.m_ack) begin
          if (r_beat == LAST) begin
            w_state_nxt = bus.b_rd_i ? DONE : IDLE;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
            if (!bus.b_rd_i) w_state_nxt = DRAIN;
          end
        end else if (!bus.b_rd_i) begin
          w_state_nxt = DRAIN;
        end
      end
      // An abandoned fetch still owes the memory one completed beat.
      DRAIN: begin
        if (bus.m_ack) w_state_nxt = IDLE;
      end
      DONE: begin
        w_buf_v_nxt = !bus.inv;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_buf_v    <= 1'b0;
      r_buf_addr <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_buf_v    <= w_buf_v_nxt;
      r_buf_addr <= w_buf_addr_nxt;
      if (w_beat_we) r_data[int'(r_beat) * MEM_W +: MEM_W] <= bus.m_data;
    end
  end
endmodule

// File: doc/imem_fill.md
Name: imem_fill

Overview:
- Responder side of the L1 instruction-cache line-fill interface.
- Accepts line requests on `b_rd_i`/`b_addr_i` and fetches the line as `MEM_W`-bit beats from the backing memory port.
- Assembles the beats into one line and returns it with a single-cycle `b_dv_i` pulse.
- Keeps the last filled line in a one-entry buffer, so a back-to-back request for the same line is served in 1 cycle without a memory access.

Parameters:
LINE     256  line width in bits; must equal the cache line width; multiple of MEM_W
MEM_W    64   backing memory data width in bits; power of two, >= 8
BLK_LEN  59   line address width = 64 - log2(LINE/8)

Ports:
clk       in   1         clock, all logic on rising edge
rst_n     in   1         synchronous active-low reset
b_addr_i  in   BLK_LEN   requested line address; valid while b_rd_i=1
b_rd_i    in   1         line request; held high by cache until it sees b_dv_i
b_data_i  out  LINE      line data; beat k at bits [k*MEM_W +: MEM_W]
b_dv_i    out  1         line valid; one-cycle pulse
inv       in   1         invalidate line buffer (fence.i)
m_addr    out  64        memory byte address, MEM_W-aligned
m_rd      out  1         memory read request
m_data    in   MEM_W     memory read data; valid when m_ack=1
m_ack     in   1         memory beat done; may be asserted in the same cycle m_rd first rises

Behaviour:

Constants:
- BEATS = LINE/MEM_W.
- Beat counter width = max(1, log2 BEATS).

Reset (rst_n=0 at a posedge), regardless of state, including mid-fetch:
- state=IDLE, beat=0, buf_v=0.
- b_dv_i=0, m_rd=0, m_addr=0, b_data_i=0.
- Any in-flight memory beat is abandoned; the memory side is reset with the same rst_n.

States:
- IDLE:
  - If b_rd_i=1 && buf_v && !inv && b_addr_i==buf_addr: go DONE (buffer hit).
  - Else if b_rd_i=1: latch b_addr_i into buf_addr, clear buf_v, beat=0, go REQ.
  - inv=1 clears buf_v in any state.
- REQ:
  - m_rd=1.
  - m_addr = {buf_addr, log2(LINE/8) zero bits} + beat*(MEM_W/8), truncated to 64 bits.
  - On m_ack: write m_data into b_data_i[beat*MEM_W +: MEM_W].
    - If beat==BEATS-1: go DONE.
    - Else beat+1 and stay in REQ; m_rd stays high with no idle cycle between beats.
  - If b_rd_i=0 in a cycle without m_ack: go DRAIN.
  - If b_rd_i=0 in the same cycle as m_ack: the ack is consumed, then go DRAIN for any further beats. If that ack was the final beat, go IDLE with no b_dv_i.
- DRAIN:
  - m_rd=1, m_addr unchanged, until m_ack; discard data, go IDLE.
  - buf_v stays 0 and b_dv_i is never asserted.
  - m_rd must never drop before m_ack once raised.
- DONE:
  - b_dv_i=1 for exactly this cycle.
  - b_data_i holds the complete line.
  - Set buf_v=1 unless inv=1 this cycle; inv wins, but the pulse still occurs.
  - Go IDLE. The cache drops b_rd_i on the following cycle, so IDLE never re-triggers on a stale request.

Outputs and timing:
- b_data_i is registered and stable outside REQ.
- Under REQ it shows a partially filled line; consumers use it only when b_dv_i=1.
- b_dv_i and m_rd are decoded from registered state only; there is no combinational path from b_rd_i.
- Latency, request sampled at cycle 0 with a zero-wait memory: REQ at cycles 1..BEATS, b_dv_i at cycle BEATS+1.
- Each memory wait state adds 1 cycle.
- Buffer-hit latency: b_dv_i at cycle 1.
- Address arithmetic wraps modulo 2^64; no overflow flag.

Test Plan:
- Reset, then b_rd_i=1, b_addr_i=0x10, zero-wait memory returning beat k = 0x1111_1111_1111_1111*(k+1) -> m_addr 0x200,0x208,0x210,0x218 on cycles 1..4; b_dv_i pulse at cycle 5; b_data_i = {0x44..,0x33..,0x22..,0x11..}; b_dv_i low thereafter.
- Same address re-requested two cycles later -> b_dv_i on the next cycle, identical data, m_rd stays 0. Then assert inv for 1 cycle and re-request -> full 4-beat fetch.
- Memory with 2 wait states per beat -> m_rd continuously high, m_addr stable until each ack, b_dv_i at cycle 13.
- Drop b_rd_i after beat 1 acked while beat 2 pending -> m_rd held until beat 2 ack, then 0; no b_dv_i; next request to same address performs a full fetch (buffer not valid).
- rst_n=0 during beat 2 of a fetch -> next cycle m_rd=0, b_dv_i=0, b_data_i=0; subsequent request refetches from beat 0.
